arb_requester: RTL and testbench
================================

ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 15: max cycles spent in REQ awaiting grant (range 1-255).
REQ-002 SHALL provide parameter LEN_W, default 4: width of hold-length inputs.
REQ-003 SHALL have clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 SHALL have start  input  2  per-channel job start; bit i is sampled only while channel i is in IDLE.
REQ-006 SHALL have len0  input  LEN_W  channel 0 hold length; sampled on the grant-accept edge.
REQ-007 SHALL have len1  input  LEN_W  channel 1 hold length; same sampling rule as len0.
REQ-008 SHALL have grant  input  2  one-hot grant from the arbiter; 2'b00 means idle.
REQ-009 SHALL have request  output  2  registered request to the arbiter, one bit per channel.
REQ-010 SHALL have busy  output  2  channel i is not in IDLE.
REQ-011 SHALL have done  output  2  one-cycle pulse when channel i completes its hold normally.
REQ-012 SHALL have timeout  output  2  one-cycle pulse when channel i abandons REQ without a grant.
REQ-013 SHALL have lost  output  2  one-cycle pulse when grant[i] drops during OWN.
REQ-014 SHALL have proto_err  output  1  sticky flag for an arbiter protocol violation.

Function
REQ-015 SHALL implement two identical, independent channel FSMs with states IDLE, REQ and OWN.
REQ-016 IDLE: start[i]=1 at a posedge SHALL move the channel to REQ; request[i]=1 from that edge onward.
REQ-017 REQ: request[i] SHALL be held at 1; a wait counter SHALL increment each cycle, starting from 0 on entry.
REQ-018 REQ: grant[i]=1 at a posedge SHALL move the channel to OWN, load the hold counter with len_i and clear the wait counter.
REQ-019 REQ: if the wait counter reaches TIMEOUT-1 with grant[i]=0, the next edge SHALL return the channel to IDLE, drive request[i]=0 and pulse timeout[i].
REQ-020 REQ: grant arriving on the same edge as the timeout SHALL take priority (go to OWN, no timeout pulse).
REQ-021 OWN: request[i] SHALL stay 1 and the hold counter SHALL decrement each cycle.
REQ-022 OWN: occupancy SHALL be exactly len_i+1 cycles (len=0 gives 1 cycle; max 2^LEN_W cycles); the counter SHALL NOT wrap.
REQ-023 OWN: on the final cycle the next edge SHALL go to IDLE with request[i]=0 and pulse done[i].
REQ-024 OWN: grant[i]=0 at any posedge SHALL abort to IDLE with request[i]=0 and pulse lost[i], with no done pulse.
REQ-025 done, timeout and lost SHALL be mutually exclusive per channel and each SHALL last exactly one cycle.
REQ-026 A channel SHALL NOT re-request in the cycle after returning to IDLE; start is sampled again from the following edge, so request[i] is low for at least 1 cycle.
REQ-027 start[i] SHALL be ignored while the channel is in REQ or OWN.
REQ-028 proto_err SHALL set on any edge where grant==2'b11, or where grant[i]=1 while request[i]=0.
REQ-029 proto_err SHALL remain set until reset.
REQ-030 Both channels MAY be in REQ simultaneously; each channel SHALL react only to its own grant bit.

Reset
REQ-031 rst=0 SHALL immediately, without waiting for clk, force both channels to IDLE.
REQ-032 Reset values SHALL be: request=2'b00, busy=2'b00, done=2'b00, timeout=2'b00, lost=2'b00, proto_err=0, all counters 0.
REQ-033 Reset asserted mid-REQ or mid-OWN SHALL drop request within the same reset assertion and produce no pulses.
REQ-034 After rst rises, the first posedge SHALL sample start normally.

Verification
REQ-035 Normal hold: start=01, grant=01 two cycles later, len0=3 -> request[0] high, 4 OWN cycles, done[0] pulse, request=00 one cycle after.
REQ-036 Timeout: start=10, grant held 00, TIMEOUT=15 -> request[1] high 15 cycles, then timeout[1] pulse and request=00.
REQ-037 Preemption: channel 0 in OWN with len0=7, grant drops to 00 after 2 OWN cycles -> lost[0] pulse, no done[0], request[0]=0.
REQ-038 Protocol errors: grant=11 for one cycle, or grant=01 while request=00 -> proto_err=1 and held until rst=0.
REQ-039 Async reset mid-OWN: rst=0 between clock edges -> request=00 and busy=00 before the next posedge; no done, lost or timeout pulse.
REQ-040 Concurrent operation: start=11, grant=01 then 10 -> channel 0 completes its hold (done[0]) while request[1] stays high, then channel 1 completes (done[1]); proto_err stays 0.

Source files
------------

// File: rtl/arb_requester.sv
// Two-channel bus requester: each channel requests the arbiter, holds the grant for a
// programmed number of cycles, and reports done, timeout or loss of the grant.
module arb_requester #(
   parameter int TIMEOUT = 15,
   parameter int LEN_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       start,
   input  logic [LEN_W-1:0] len0,
   input  logic [LEN_W-1:0] len1,
   input  logic [1:0]       grant,
   output logic [1:0]       request,
   output logic [1:0]       busy,
   output logic [1:0]       done,
   output logic [1:0]       timeout,
   output logic [1:0]       lost,
   output logic             proto_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      OWN  = 2'd2
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   for (genvar i = 0; i < 2; i++) begin : g_ch
      state_t           state_q, state_d;
      logic [7:0]       wcnt_q, wcnt_d;
      logic [LEN_W-1:0] hold_q, hold_d;
      logic [LEN_W-1:0] len_sel;
      logic             req_q;
      logic             done_q, done_d;
      logic             tmo_q, tmo_d;
      logic             lost_q, lost_d;

      assign len_sel = (i == 0) ? len0 : len1;

      // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
      always_comb begin
         state_d = state_q;
         wcnt_d  = wcnt_q;
         hold_d  = hold_q;
         done_d  = 1'b0;
         tmo_d   = 1'b0;
         lost_d  = 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start[i]) begin
                  state_d = REQ;
                  wcnt_d  = '0;
               end
            end
            REQ: begin
               // A grant on the timeout edge still wins.
               if (grant[i]) begin
                  state_d = OWN;
                  hold_d  = len_sel;
                  wcnt_d  = '0;
               end else if (wcnt_q == WAIT_LAST) begin
                  state_d = IDLE;
                  wcnt_d  = '0;
                  tmo_d   = 1'b1;
               end else begin
                  wcnt_d = wcnt_q + 8'd1;
               end
            end
            OWN: begin
               if (!grant[i]) begin
                  state_d = IDLE;
                  hold_d  = '0;
                  lost_d  = 1'b1;
               end else if (hold_q == '0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  hold_d = hold_q - LEN_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // NOTE: the asynchronous reset clears every flop here; there is no memory, so nothing is left unreset.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            hold_q  <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            lost_q  <= 1'b0;
         end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            hold_q  <= hold_d;
            req_q   <= (state_d != IDLE);
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            lost_q  <= lost_d;
         end
      end

      assign request[i] = req_q;
      assign busy[i]    = req_q;
      assign done[i]    = done_q;
      assign timeout[i] = tmo_q;
      assign lost[i]    = lost_q;
   end

   // Sticky: a double grant, or a grant to a channel that is not requesting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         proto_err <= 1'b0;
      end else if (grant == 2'b11 || (grant & ~request) != 2'b00) begin
         proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: directed scenarios plus randomized traffic
// compared against a cycle-counting reference model.
module tb_arb_requester;
   localparam int TIMEOUT = 15;
   localparam int LEN_W   = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       start;
   logic [LEN_W-1:0] len0;
   logic [LEN_W-1:0] len1;
   logic [1:0]       grant;
   logic [1:0]       request;
   logic [1:0]       busy;
   logic [1:0]       done;
   logic [1:0]       timeout;
   logic [1:0]       lost;
   logic             proto_err;

   int vectors     = 0;
   int miscompares = 0;

   arb_requester #(.TIMEOUT(TIMEOUT), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len0      (len0),
      .len1      (len1),
      .grant     (grant),
      .request   (request),
      .busy      (busy),
      .done      (done),
      .timeout   (timeout),
      .lost      (lost),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: -1 means "not in that activity", otherwise cycles spent so far.
   int         waited[2];
   int         owned[2];
   int         hold_total[2];
   logic [1:0] m_req, m_done, m_tmo, m_lost;
   logic       m_perr;

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         waited[i]     = -1;
         owned[i]      = -1;
         hold_total[i] = 0;
      end
      m_req = 2'b00; m_done = 2'b00; m_tmo = 2'b00; m_lost = 2'b00; m_perr = 1'b0;
   endtask

   task automatic model_edge(input logic [1:0] s, input logic [1:0] g,
                             input logic [LEN_W-1:0] l0, input logic [LEN_W-1:0] l1);
      if (g == 2'b11 || (g & ~m_req) != 2'b00) m_perr = 1'b1;
      for (int i = 0; i < 2; i++) begin
         m_done[i] = 1'b0; m_tmo[i] = 1'b0; m_lost[i] = 1'b0;
         if (owned[i] >= 0) begin
            owned[i]++;
            if (!g[i]) begin
               m_lost[i] = 1'b1; owned[i] = -1;
            end else if (owned[i] == hold_total[i]) begin
               m_done[i] = 1'b1; owned[i] = -1;
            end
         end else if (waited[i] >= 0) begin
            waited[i]++;
            if (g[i]) begin
               waited[i]     = -1;
               owned[i]      = 0;
               hold_total[i] = ((i == 0) ? int'(l0) : int'(l1)) + 1;
            end else if (waited[i] == TIMEOUT) begin
               m_tmo[i] = 1'b1; waited[i] = -1;
            end
         end else if (s[i]) begin
            waited[i] = 0;
         end
         m_req[i] = (waited[i] >= 0) || (owned[i] >= 0);
      end
   endtask

   // One clock edge: inputs held since the previous step are what the DUT samples.
   task automatic tick();
      logic [1:0]       s, g;
      logic [LEN_W-1:0] a, b;
      s = start; g = grant; a = len0; b = len1;
      @(posedge clk);
      model_edge(s, g, a, b);
      #1;
   endtask

   task automatic do_reset();
      start = 2'b00; grant = 2'b00; len0 = '0; len1 = '0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 2'b11; grant = 2'b11; len0 = '1; len1 = '1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({request, busy, done, timeout, lost, proto_err} !== 11'b0) begin
         miscompares++;
         $display("FAIL reset_state got %b exp %b", {request, busy, done, timeout, lost, proto_err}, 11'b0);
      end
      do_reset();
   endtask

   task automatic test_normal_hold();
      int n;
      do_reset();
      len0 = 4'd3; start = 2'b01;
      tick();
      vectors++;
      if (request !== 2'b01 || busy !== 2'b01) begin
         miscompares++; $display("FAIL hold_req_rise got req=%b busy=%b exp 01", request, busy);
      end
      start = 2'b00;
      tick();
      grant = 2'b01;
      tick();
      n = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         n++;
         if (done[0]) break;
         vectors++;
         if (request !== 2'b01) begin
            miscompares++; $display("FAIL hold_own_req got %b exp 01", request);
         end
      end
      vectors++;
      if (n != 4 || done !== 2'b01 || request !== 2'b00) begin
         miscompares++;
         $display("FAIL hold_done got own_cycles=%0d done=%b req=%b exp 4 01 00", n, done, request);
      end
      grant = 2'b00;
      tick();
      vectors++;
      if (done !== 2'b00 || request !== 2'b00 || proto_err !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_after got done=%b req=%b perr=%b exp 00 00 0", done, request, proto_err);
      end
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      start = 2'b10;
      tick();
      n = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         n++;
         if (timeout[1]) break;
         vectors++;
         if (request !== 2'b10) begin
            miscompares++; $display("FAIL tmo_wait_req got %b exp 10", request);
         end
      end
      vectors++;
      if (n != TIMEOUT || timeout !== 2'b10 || request !== 2'b00 || done !== 2'b00) begin
         miscompares++;
         $display("FAIL tmo_pulse got cycles=%0d tmo=%b req=%b done=%b exp %0d 10 00 00",
                  n, timeout, request, done, TIMEOUT);
      end
      // start held high the whole time: re-request after exactly one low cycle.
      tick();
      vectors++;
      if (timeout !== 2'b00 || request !== 2'b10) begin
         miscompares++;
         $display("FAIL tmo_rerequest got tmo=%b req=%b exp 00 10", timeout, request);
      end
      start = 2'b00;
   endtask

   task automatic test_preempt();
      do_reset();
      len0 = 4'd7; start = 2'b01;
      tick();
      start = 2'b00; grant = 2'b01;
      tick();
      tick();
      tick();
      grant = 2'b00;
      tick();
      vectors++;
      if (lost !== 2'b01 || done !== 2'b00 || request !== 2'b00) begin
         miscompares++;
         $display("FAIL preempt_lost got lost=%b done=%b req=%b exp 01 00 00", lost, done, request);
      end
      tick();
      vectors++;
      if (lost !== 2'b00 || done !== 2'b00 || proto_err !== 1'b0) begin
         miscompares++;
         $display("FAIL preempt_after got lost=%b done=%b perr=%b exp 00 00 0", lost, done, proto_err);
      end
   endtask

   task automatic test_proto_err();
      do_reset();
      grant = 2'b11;
      tick();
      grant = 2'b00;
      vectors++;
      if (proto_err !== 1'b1) begin
         miscompares++; $display("FAIL perr_double got %b exp 1", proto_err);
      end
      repeat (3) tick();
      vectors++;
      if (proto_err !== 1'b1) begin
         miscompares++; $display("FAIL perr_sticky got %b exp 1", proto_err);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++;
      if (proto_err !== 1'b0) begin
         miscompares++; $display("FAIL perr_clear got %b exp 0", proto_err);
      end
      do_reset();
      grant = 2'b01;
      tick();
      grant = 2'b00;
      vectors++;
      if (proto_err !== 1'b1 || request !== 2'b00) begin
         miscompares++;
         $display("FAIL perr_unrequested got perr=%b req=%b exp 1 00", proto_err, request);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      len0 = 4'd15; start = 2'b01;
      tick();
      start = 2'b00; grant = 2'b01;
      tick();
      tick();
      #3;
      rst = 1'b0;
      #1;
      vectors++;
      if ({request, busy, done, timeout, lost} !== 10'b0) begin
         miscompares++;
         $display("FAIL async_drop got %b exp %b", {request, busy, done, timeout, lost}, 10'b0);
      end
      @(posedge clk);
      #1;
      vectors++;
      if ({request, busy, done, timeout, lost, proto_err} !== 11'b0) begin
         miscompares++;
         $display("FAIL async_hold got %b exp %b", {request, busy, done, timeout, lost, proto_err}, 11'b0);
      end
      grant = 2'b00;
      rst = 1'b1;
      model_reset();
      start = 2'b10;
      tick();
      start = 2'b00;
      vectors++;
      if (request !== 2'b10 || done !== 2'b00 || lost !== 2'b00) begin
         miscompares++;
         $display("FAIL async_first_edge got req=%b done=%b lost=%b exp 10 00 00", request, done, lost);
      end
   endtask

   task automatic test_concurrent();
      int n;
      do_reset();
      len0 = 4'd2; len1 = 4'd3; start = 2'b11;
      tick();
      start = 2'b00; grant = 2'b01;
      tick();
      n = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         n++;
         if (done[0]) break;
         vectors++;
         if (request !== 2'b11 || proto_err !== 1'b0) begin
            miscompares++;
            $display("FAIL conc_ch0_own got req=%b perr=%b exp 11 0", request, proto_err);
         end
      end
      vectors++;
      if (n != 3 || done !== 2'b01 || request !== 2'b10) begin
         miscompares++;
         $display("FAIL conc_ch0_done got cycles=%0d done=%b req=%b exp 3 01 10", n, done, request);
      end
      grant = 2'b10;
      tick();
      n = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         n++;
         if (done[1]) break;
      end
      vectors++;
      if (n != 4 || done !== 2'b10 || request !== 2'b00 || proto_err !== 1'b0) begin
         miscompares++;
         $display("FAIL conc_ch1_done got cycles=%0d done=%b req=%b perr=%b exp 4 10 00 0",
                  n, done, request, proto_err);
      end
      grant = 2'b00;
      tick();
   endtask

   task automatic test_random(input int cycles, input int err_per_mille);
      logic [1:0]  g;
      logic [10:0] got, exp;
      int          owner;
      do_reset();
      for (int c = 0; c < cycles; c++) begin
         g = 2'b00;
         owner = (owned[0] >= 0) ? 0 : ((owned[1] >= 0) ? 1 : -1);
         if (owner >= 0) begin
            if ($urandom_range(0, 99) < 93) g[owner] = 1'b1;
         end else if ($urandom_range(0, 99) < 30) begin
            if (waited[0] >= 0 && waited[1] >= 0) g[$urandom_range(0, 1)] = 1'b1;
            else if (waited[0] >= 0) g[0] = 1'b1;
            else if (waited[1] >= 0) g[1] = 1'b1;
         end
         if ($urandom_range(0, 999) < err_per_mille) g = 2'($urandom_range(0, 3));
         grant = g;
         start = ($urandom_range(0, 99) < 40) ? 2'($urandom_range(0, 3)) : 2'b00;
         len0  = LEN_W'($urandom_range(0, 15));
         len1  = LEN_W'($urandom_range(0, 15));
         tick();
         got = {request, busy, done, timeout, lost, proto_err};
         exp = {m_req, m_req, m_done, m_tmo, m_lost, m_perr};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL random cycle %0d got req/busy/done/tmo/lost/perr=%b exp %b", c, got, exp);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_normal_hold();
      test_timeout();
      test_preempt();
      test_proto_err();
      test_async_reset();
      test_concurrent();
      test_random(2500, 0);
      test_random(1500, 5);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
